// File: rtl/nrzi_eop_encoder.sv
// NRZI line encoder for the USB transmit path: turns the stuffed bitstream into
// dp/dm levels and appends SE0 x EOP_SE0_BITS followed by one J bit as End-of-Packet.
module nrzi_eop_encoder #(
  parameter int EOP_SE0_BITS = 2,
  parameter int CNT_W        = 16
) (
  input  logic             clock,
  input  logic             reset,
  input  logic             in_bit,
  input  logic             in_valid,
  output logic             dp,
  output logic             dm,
  output logic             out_en,
  output logic             busy,
  output logic             eop_done,
  output logic [CNT_W-1:0] bit_count,
  output logic             restart_err
);

  typedef enum logic [1:0] {
    IDLE    = 2'd0,
    SEND    = 2'd1,
    EOP_SE0 = 2'd2,
    EOP_J   = 2'd3
  } state_t;

  localparam logic [2:0]       SE0_LAST = 3'(EOP_SE0_BITS);
  localparam logic [CNT_W-1:0] CNT_MAX  = '1;
  localparam logic [CNT_W-1:0] CNT_ONE  = CNT_W'(1);

  state_t           state, state_next;
  logic             level, level_next;      // 1 = J, 0 = K
  logic [2:0]       se0_cnt, se0_cnt_next;
  logic             dp_next, dm_next;
  logic             out_en_next, busy_next, eop_done_next, restart_err_next;
  logic [CNT_W-1:0] bit_count_next;
  logic             send_level;

  // A 1 holds the line level, a 0 toggles it.
  assign send_level = in_bit ? level : ~level;

  always_comb begin
    state_next       = state;
    level_next       = level;
    se0_cnt_next     = se0_cnt;
    dp_next          = dp;
    dm_next          = dm;
    out_en_next      = out_en;
    eop_done_next    = 1'b0;
    bit_count_next   = bit_count;
    restart_err_next = restart_err;

    case (state)
      IDLE: begin
        dp_next     = 1'b1;
        dm_next     = 1'b0;
        out_en_next = 1'b0;
        if (in_valid) begin
          // Every packet starts encoding from J, whatever the last packet ended on.
          level_next     = in_bit;
          dp_next        = in_bit;
          dm_next        = ~in_bit;
          out_en_next    = 1'b1;
          bit_count_next = CNT_ONE;
          state_next     = SEND;
        end
      end

      SEND: begin
        if (in_valid) begin
          level_next = send_level;
          dp_next    = send_level;
          dm_next    = ~send_level;
          if (bit_count != CNT_MAX)
            bit_count_next = bit_count + CNT_ONE;
        end else begin
          dp_next      = 1'b0;
          dm_next      = 1'b0;
          se0_cnt_next = 3'd1;
          state_next   = EOP_SE0;
        end
      end

      EOP_SE0: begin
        if (in_valid)
          restart_err_next = 1'b1;
        if (se0_cnt < SE0_LAST) begin
          dp_next      = 1'b0;
          dm_next      = 1'b0;
          se0_cnt_next = se0_cnt + 3'd1;
        end else begin
          dp_next       = 1'b1;
          dm_next       = 1'b0;
          eop_done_next = 1'b1;
          state_next    = EOP_J;
        end
      end

      EOP_J: begin
        if (in_valid)
          restart_err_next = 1'b1;
        dp_next     = 1'b1;
        dm_next     = 1'b0;
        out_en_next = 1'b0;
        level_next  = 1'b1;
        state_next  = IDLE;
      end

      default: begin
        dp_next     = 1'b1;
        dm_next     = 1'b0;
        out_en_next = 1'b0;
        level_next  = 1'b1;
        state_next  = IDLE;
      end
    endcase

    busy_next = (state_next != IDLE);
  end

  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      state       <= IDLE;
      level       <= 1'b1;
      se0_cnt     <= 3'd0;
      dp          <= 1'b1;
      dm          <= 1'b0;
      out_en      <= 1'b0;
      busy        <= 1'b0;
      eop_done    <= 1'b0;
      bit_count   <= '0;
      restart_err <= 1'b0;
    end else begin
      state       <= state_next;
      level       <= level_next;
      se0_cnt     <= se0_cnt_next;
      dp          <= dp_next;
      dm          <= dm_next;
      out_en      <= out_en_next;
      busy        <= busy_next;
      eop_done    <= eop_done_next;
      bit_count   <= bit_count_next;
      restart_err <= restart_err_next;
    end
  end

endmodule
